// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: round-robin write arbitration plus head/tail/count sequencing for a 4-entry register FIFO
module fifo_wr_arb_ctrl #(
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req0,
  input  logic                  wr_req1,
  input  logic                  rd_req,
  output logic                  wr_gnt0,
  output logic                  wr_gnt1,
  output logic                  wr_sel,
  output logic [2**PTR_W-1:0]   wr_en,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic                  rd_valid,
  output logic [PTR_W:0]        count,
  output logic                  fifo_full,
  output logic                  fifo_empty
);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             last_gnt_q, last_gnt_d, wr_acc, rd_acc;
  always_comb begin
    fifo_full  = count_q[PTR_W];  // the top bit also covers the unreachable 5..7 codes
    fifo_empty = count_q == '0;
    wr_acc     = (wr_req0 | wr_req1) & ~fifo_full & ~rst;
    rd_acc     = rd_req & ~fifo_empty & ~rst;
    wr_gnt1    = wr_acc & wr_req1 & (~wr_req0 | ~last_gnt_q);
    wr_gnt0    = wr_acc & ~wr_gnt1;
    wr_sel     = wr_gnt1;
    wr_en      = '0;
    wr_en[tail_q] = wr_acc;
    rd_ptr     = head_q;
    rd_valid   = ~fifo_empty;
    count      = count_q;
    head_d     = head_q + (PTR_W)'(rd_acc);
    tail_d     = tail_q + (PTR_W)'(wr_acc);
    count_d    = count_q + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(rd_acc);
    last_gnt_d = wr_acc ? wr_gnt1 : last_gnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      last_gnt_q <= last_gnt_d;
    end
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// tb_fifo_wr_arb_ctrl: directed vector table, async reset sequence and randomized run against a queue model
module tb_fifo_wr_arb_ctrl;
  logic clk = 0, rst = 1, wr_req0 = 0, wr_req1 = 0, rd_req = 0;
  logic wr_gnt0, wr_gnt1, wr_sel, rd_valid, fifo_full, fifo_empty;
  logic [3:0] wr_en;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  int checks = 0, errors = 0;
  int q[$];
  int pops = 0;
  bit last = 1;

  fifo_wr_arb_ctrl #(.PTR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_req0(wr_req0), .wr_req1(wr_req1), .rd_req(rd_req),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .wr_sel(wr_sel), .wr_en(wr_en),
    .rd_ptr(rd_ptr), .rd_valid(rd_valid), .count(count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, a, b, d;
    logic g0, g1, sel;
    logic [3:0] en;
    logic [1:0] ptr;
    logic [2:0] cnt;
    logic full, empty;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic b, input logic d);
    @(negedge clk);
    rst = r; wr_req0 = a; wr_req1 = b; rd_req = d;
    #2;
  endtask

  // Model: queue of slot indices; head = total pops mod 4, tail = head + occupancy mod 4
  task automatic model_step(input string tag);
    int sz, tail, win;
    bit acc, racc;
    if (rst) begin q.delete(); pops = 0; last = 1; end
    sz = q.size();
    tail = (pops + sz) % 4;
    acc = !rst && (wr_req0 || wr_req1) && sz < 4;
    racc = !rst && rd_req && sz > 0;
    win = (wr_req0 && wr_req1) ? int'(!last) : int'(wr_req1);
    chk({tag, ".gnt0"}, {7'd0, wr_gnt0}, {7'd0, acc && win == 0});
    chk({tag, ".gnt1"}, {7'd0, wr_gnt1}, {7'd0, acc && win == 1});
    chk({tag, ".sel"}, {7'd0, wr_sel}, {7'd0, acc && win == 1});
    chk({tag, ".wr_en"}, {4'd0, wr_en}, acc ? 8'(1 << tail) : 8'd0);
    chk({tag, ".rd_ptr"}, {6'd0, rd_ptr}, 8'(pops % 4));
    chk({tag, ".count"}, {5'd0, count}, 8'(sz));
    chk({tag, ".full"}, {7'd0, fifo_full}, {7'd0, sz == 4});
    chk({tag, ".empty"}, {7'd0, fifo_empty}, {7'd0, sz == 0});
    chk({tag, ".rd_valid"}, {7'd0, rd_valid}, {7'd0, sz != 0});
    if (!rst) begin
      if (racc) begin void'(q.pop_front()); pops++; end
      if (acc) begin q.push_back(tail); last = bit'(win); end
    end
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0, 0,0,0,4'b0000,2'd0,3'd0,0,1};
    tbl[1]  = '{0,1,0,0, 1,0,0,4'b0001,2'd0,3'd0,0,1};
    tbl[2]  = '{0,1,0,0, 1,0,0,4'b0010,2'd0,3'd1,0,0};
    tbl[3]  = '{0,1,0,0, 1,0,0,4'b0100,2'd0,3'd2,0,0};
    tbl[4]  = '{0,1,0,0, 1,0,0,4'b1000,2'd0,3'd3,0,0};
    tbl[5]  = '{0,1,0,0, 0,0,0,4'b0000,2'd0,3'd4,1,0};
    tbl[6]  = '{0,0,1,1, 0,0,0,4'b0000,2'd0,3'd4,1,0};
    tbl[7]  = '{0,0,1,0, 0,1,1,4'b0001,2'd1,3'd3,0,0};
    tbl[8]  = '{0,0,0,1, 0,0,0,4'b0000,2'd1,3'd4,1,0};
    tbl[9]  = '{0,0,0,1, 0,0,0,4'b0000,2'd2,3'd3,0,0};
    tbl[10] = '{0,0,0,1, 0,0,0,4'b0000,2'd3,3'd2,0,0};
    tbl[11] = '{0,0,0,1, 0,0,0,4'b0000,2'd0,3'd1,0,0};
    tbl[12] = '{0,1,0,1, 1,0,0,4'b0010,2'd1,3'd0,0,1};
    tbl[13] = '{0,1,1,1, 0,1,1,4'b0100,2'd1,3'd1,0,0};
    tbl[14] = '{0,1,1,1, 1,0,0,4'b1000,2'd2,3'd1,0,0};
    tbl[15] = '{0,1,1,1, 0,1,1,4'b0001,2'd3,3'd1,0,0};
    tbl[16] = '{0,0,0,0, 0,0,0,4'b0000,2'd0,3'd1,0,0};
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].d);
      chk($sformatf("vec%0d.gnt0", i), {7'd0, wr_gnt0}, {7'd0, tbl[i].g0});
      chk($sformatf("vec%0d.gnt1", i), {7'd0, wr_gnt1}, {7'd0, tbl[i].g1});
      chk($sformatf("vec%0d.sel", i), {7'd0, wr_sel}, {7'd0, tbl[i].sel});
      chk($sformatf("vec%0d.wr_en", i), {4'd0, wr_en}, {4'd0, tbl[i].en});
      chk($sformatf("vec%0d.rd_ptr", i), {6'd0, rd_ptr}, {6'd0, tbl[i].ptr});
      chk($sformatf("vec%0d.count", i), {5'd0, count}, {5'd0, tbl[i].cnt});
      chk($sformatf("vec%0d.full", i), {7'd0, fifo_full}, {7'd0, tbl[i].full});
      chk($sformatf("vec%0d.empty", i), {7'd0, fifo_empty}, {7'd0, tbl[i].empty});
      model_step($sformatf("vecm%0d", i));
    end
    // asynchronous reset mid-cycle with three entries held
    drive(1, 0, 0, 0); model_step("ar.rst0");
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); model_step("ar.wr"); end
    @(negedge clk);
    wr_req0 = 0;
    chk("ar.pre_count", {5'd0, count}, 8'd3);
    #1 rst = 1;
    #1;
    chk("ar.count", {5'd0, count}, 8'd0);
    chk("ar.empty", {7'd0, fifo_empty}, 8'd1);
    chk("ar.rd_ptr", {6'd0, rd_ptr}, 8'd0);
    chk("ar.wr_en", {4'd0, wr_en}, 8'd0);
    wr_req0 = 1; wr_req1 = 1;
    #1;
    chk("ar.no_gnt", {6'd0, wr_gnt1, wr_gnt0}, 8'd0);
    drive(1, 0, 0, 0); model_step("ar.hold");
    // random traffic with phases biased toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      logic r, d;
      r = $urandom_range(0, 99) == 0;
      d = $urandom_range(0, 3) < (((i / 150) % 2) ? 3 : 1);
      drive(r, 1'($urandom), 1'($urandom), d);
      model_step("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb_ctrl.md
# fifo_wr_arb_ctrl

Sequencing and arbitration controller for the team's 4-entry register FIFO. It shares the FIFO's single write port between two producers using round-robin arbitration. It also owns the head pointer, tail pointer and occupancy count, and drives the per-entry load enables and the read-side select. It sits between the producers/consumer and the FIFO entry registers, and it replaces the separate head/tail pointer logic.

## Interface
Parameters:
- PTR_W, 2, pointer width. Depth is 2**PTR_W = 4; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_req0  in  1  producer 0 requests a write this cycle
- wr_req1  in  1  producer 1 requests a write this cycle
- rd_req  in  1  consumer pops the head entry this cycle
- wr_gnt0  out  1  producer 0's write is accepted this cycle (combinational)
- wr_gnt1  out  1  producer 1's write is accepted this cycle (combinational)
- wr_sel  out  1  data mux select into the entries: 0 = producer 0, 1 = producer 1
- wr_en  out  4  one-hot load enable for the entry at the tail; 0000 when no write is accepted
- rd_ptr  out  2  head index driving the output data mux
- rd_valid  out  1  head entry is valid (equals ~fifo_empty)
- count  out  3  occupancy, 0..4
- fifo_full  out  1  count == 4
- fifo_empty  out  1  count == 0

## Operation
- Registered state:
  - head[1:0] and tail[1:0], both incrementing mod 4
  - count[2:0]
  - last_gnt (1 bit: the producer that won the last accepted write)
- Write acceptance: wr_acc = (wr_req0 | wr_req1) & ~fifo_full.
  - There is no write-through when full, even if a read occurs in the same cycle.
- Arbitration when wr_acc and both requesters are active: grant the producer ≠ last_gnt.
  - With one requester active, that requester wins.
  - Exactly zero or one grant is high.
  - wr_sel = index of the granted producer; wr_sel = 0 when there is no grant.
- last_gnt updates to the winner only on an accepted write. It holds otherwise.
- Read acceptance: rd_acc = rd_req & ~fifo_empty.
  - There is no bypass: on an empty FIFO, a write in the same cycle does not satisfy a read.
- On wr_acc: wr_en[tail] = 1, and tail advances by 1 at the edge.
- On rd_acc: head advances by 1 at the edge. rd_ptr = head.
- count update:
  - +1 on write only
  - −1 on read only
  - unchanged when both or neither occur
- Wrap-around: tail and head go from 3 to 0. full/empty are determined from count only, never from pointer compare.
- Illegal count values (5..7) are unreachable. If reached, treat them as full.

## Timing
- Grants, wr_en, wr_sel and rd_acc are combinational from the current state and inputs, within the same cycle as the request.
- A written entry is visible to the consumer from the cycle after the write edge.
  - fifo_empty falls and rd_valid rises one cycle after the first write.
- fifo_full rises on the edge that accepts the 4th outstanding write. It falls on the edge of the next accepted read.
- Reset values, applied immediately on rst assertion without waiting for clk:
  - head = 0, tail = 0, count = 0, last_gnt = 1 (producer 0 wins the first contention)
  - Outputs: fifo_empty = 1, fifo_full = 0, rd_valid = 0, rd_ptr = 0, wr_en = 0000, wr_gnt0/1 = 0, wr_sel = 0
- Reset during operation discards all contents; the FIFO is empty on release.
- While rst is high, no grants are issued regardless of requests.
- The first accepted write can occur on the first rising edge after rst deasserts.

## Test plan
- Reset with count = 3, rst asserted between clock edges → count = 0, fifo_empty = 1, rd_ptr = 0, wr_en = 0000 before the next edge.
- wr_req0 held high for 5 cycles from empty, no reads:
  - wr_gnt0 = 1 in cycles 1–4, with wr_en = 0001, 0010, 0100, 1000
  - fifo_full = 1 after the 4th edge
  - cycle 5: wr_gnt0 = 0, wr_en = 0000, count = 4
- Both producers requesting continuously from reset, rd_req high:
  - grants alternate 0, 1, 0, 1, …
  - wr_sel tracks the granted producer
  - count settles at 1 and stays constant
- Full FIFO with wr_req1 = 1 and rd_req = 1:
  - only the read is accepted; count 4 → 3, rd_ptr advances
  - next cycle: wr_gnt1 = 1, and wr_en selects the freed slot
- Wrap: 4 writes, then 4 reads, then 2 writes:
  - rd_ptr returns to 0
  - the 5th write has wr_en = 0001 and the 6th has 0010
  - count = 2, fifo_empty = 0
- Empty FIFO with wr_req0 = 1 and rd_req = 1 in the same cycle:
  - write accepted, read not accepted, count 0 → 1
  - rd_valid = 1 next cycle
